ph_fold_sched: RTL and testbench

Fold scheduler for the phi pattern detectors. Each BX is time-multiplexed into FOLD sub-clock slots. The block generates the fold index shared by all pattern detectors and keeps it aligned to the BX strobe with a flywheel and lock/miss supervision. It also gathers the per-fold quality codes returned by the detectors into one per-BX result, including the best code and its fold. It sits between the BX timing distribution and the array of phi pattern detectors.

---
 rtl/ph_fold_sched.sv | 213 +++++++++++++++++++++
 tb/tb_ph_fold_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ph_fold_sched.sv
// Fold scheduler: generates the shared fold index, keeps it aligned to the BX strobe
// with a flywheel plus lock/miss supervision, and gathers per-fold quality codes per BX.
module ph_fold_sched #(
    parameter int FOLD     = 3,
    parameter int QW       = 6,
    parameter int QLAT     = 1,
    parameter int MISS_MAX = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 bx_strobe,
    output logic [2:0]           foldn,
    output logic                 fold_first,
    input  logic [QW-1:0]        qcode_in,
    output logic [FOLD*QW-1:0]   qcode_out,
    output logic [QW-1:0]        qbest,
    output logic [2:0]           qbest_fold,
    output logic                 qvalid,
    output logic                 lock,
    output logic                 sync_err,
    output logic [7:0]           err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_CONFIRM = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    localparam logic [2:0] LAST_FOLD = 3'(FOLD - 1);
    localparam logic [7:0] MISS_LIM  = 8'(MISS_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_foldn;
    logic [7:0]        r_miss;
    logic              r_sync_err;
    logic [7:0]        r_err_cnt;

    logic [2:0]        r_fold_d [QLAT];
    logic [QLAT-1:0]   r_sv_d;
    logic [QW-1:0]     r_slot   [FOLD];
    logic [FOLD-1:0]   r_wr;
    logic [FOLD*QW-1:0] r_qcode_out;
    logic [QW-1:0]     r_qbest;
    logic [2:0]        r_qbest_fold;
    logic              r_qvalid;

    logic              w_active;
    logic              w_exp;
    logic              w_realign;
    logic              w_sync_err;
    logic              w_lock_loss;
    logic              w_clear;
    logic [2:0]        w_fold_o;
    logic              w_sv_o;
    logic [QW-1:0]     w_slot_m [FOLD];
    logic [FOLD-1:0]   w_wr_m;
    logic              w_emit;
    logic [FOLD*QW-1:0] w_pack;
    logic [QW-1:0]     w_best;
    logic [2:0]        w_best_fold;

    // Supervision events, all qualified by the current (registered) state.
    assign w_active    = (r_state != S_IDLE);
    assign w_exp       = (r_foldn == LAST_FOLD);
    assign w_realign   = en && w_active && bx_strobe && !w_exp;
    assign w_sync_err  = en && bx_strobe && !w_exp &&
                         ((r_state == S_CONFIRM) || (r_state == S_LOCKED));
    assign w_lock_loss = en && (r_state == S_LOCKED) && w_exp && !bx_strobe &&
                         ((r_miss + 8'd1) >= MISS_LIM);
    assign w_clear     = !en || w_realign;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path through the case leaves the target unassigned (no latch).
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_ACQUIRE;
                S_ACQUIRE: if (bx_strobe) w_state_nxt = S_CONFIRM;
                S_CONFIRM: begin
                    if (bx_strobe && w_exp)       w_state_nxt = S_LOCKED;
                    else if (!bx_strobe && w_exp) w_state_nxt = S_ACQUIRE;
                end
                S_LOCKED: begin
                    if (bx_strobe && !w_exp) w_state_nxt = S_CONFIRM;
                    else if (w_lock_loss)    w_state_nxt = S_ACQUIRE;
                end
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        lock       = (r_state == S_LOCKED);
        fold_first = w_active && (r_foldn == 3'd0);
    end

    // Flywheel, miss counter and error supervision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_foldn    <= 3'd0;
            r_miss     <= 8'd0;
            r_sync_err <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            if (!en || !w_active || bx_strobe || w_exp) r_foldn <= 3'd0;
            else                                         r_foldn <= r_foldn + 3'd1;

            if (w_state_nxt != S_LOCKED) r_miss <= 8'd0;
            else if (w_exp)              r_miss <= bx_strobe ? 8'd0 : r_miss + 8'd1;

            r_sync_err <= w_sync_err;
            if ((w_sync_err || w_lock_loss) && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Fold/slot-valid delay line matching the detector latency; a clear kills in-flight slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sv_d <= '0;
            for (int i = 0; i < QLAT; i++) r_fold_d[i] <= 3'd0;
        end else begin
            r_sv_d[0]   <= w_active && !w_clear;
            r_fold_d[0] <= r_foldn;
            for (int i = 1; i < QLAT; i++) begin
                r_sv_d[i]   <= r_sv_d[i-1] && !w_clear;
                r_fold_d[i] <= r_fold_d[i-1];
            end
        end
    end

    assign w_fold_o = r_fold_d[QLAT-1];
    assign w_sv_o   = r_sv_d[QLAT-1];

    // Merge this cycle's code so the last fold is emitted without an extra cycle.
    always_comb begin
        w_slot_m = r_slot;
        w_wr_m   = r_wr;
        for (int k = 0; k < FOLD; k++) begin
            if (w_sv_o && (w_fold_o == 3'(k))) begin
                w_slot_m[k] = qcode_in;
                w_wr_m[k]   = 1'b1;
            end
        end
        w_emit = w_sv_o && (w_fold_o == LAST_FOLD) && (&w_wr_m) && !w_clear;
    end

    // Pack slots and pick the best code; strict compare keeps the lowest fold on ties.
    always_comb begin
        w_pack      = '0;
        w_best      = w_slot_m[0];
        w_best_fold = 3'd0;
        for (int k = 0; k < FOLD; k++) begin
            w_pack[k*QW +: QW] = w_slot_m[k];
            if (w_slot_m[k] > w_best) begin
                w_best      = w_slot_m[k];
                w_best_fold = 3'(k);
            end
        end
    end

    // NOTE: slot storage has no reset; the written flags gate every use of its contents.
    always_ff @(posedge clk) begin
        r_slot <= w_slot_m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr         <= '0;
            r_qcode_out  <= '0;
            r_qbest      <= '0;
            r_qbest_fold <= 3'd0;
            r_qvalid     <= 1'b0;
        end else begin
            if (w_clear || w_emit) r_wr <= '0;
            else                   r_wr <= w_wr_m;

            r_qvalid <= w_emit;
            if (w_emit) begin
                r_qcode_out  <= w_pack;
                r_qbest      <= w_best;
                r_qbest_fold <= w_best_fold;
            end
        end
    end

    assign foldn      = r_foldn;
    assign sync_err   = r_sync_err;
    assign err_cnt    = r_err_cnt;
    assign qcode_out  = r_qcode_out;
    assign qbest      = r_qbest;
    assign qbest_fold = r_qbest_fold;
    assign qvalid     = r_qvalid;

endmodule

// File: tb/tb_ph_fold_sched.sv
// Directed bench for ph_fold_sched (FOLD=3, QW=6, QLAT=1, MISS_MAX=2).
// Detector codes are replayed one cycle behind a bench-side fold counter.
module tb_ph_fold_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        bx_strobe;
    logic [2:0]  foldn;
    logic        fold_first;
    logic [5:0]  qcode_in;
    logic [17:0] qcode_out;
    logic [5:0]  qbest;
    logic [2:0]  qbest_fold;
    logic        qvalid;
    logic        lock;
    logic        sync_err;
    logic [7:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] tbl [3];
    logic [2:0] m_fold;
    logic [2:0] m_prev;
    logic       m_active;

    ph_fold_sched #(.FOLD(3), .QW(6), .QLAT(1), .MISS_MAX(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bx_strobe  (bx_strobe),
        .foldn      (foldn),
        .fold_first (fold_first),
        .qcode_in   (qcode_in),
        .qcode_out  (qcode_out),
        .qbest      (qbest),
        .qbest_fold (qbest_fold),
        .qvalid     (qvalid),
        .lock       (lock),
        .sync_err   (sync_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; the fold counter here only schedules the detector codes.
    task automatic step();
        logic [2:0] nf;
        @(posedge clk);
        if (!en || !m_active)     nf = 3'd0;
        else if (bx_strobe)       nf = 3'd0;
        else if (m_fold == 3'd2)  nf = 3'd0;
        else                      nf = m_fold + 3'd1;
        m_active = en;
        m_prev   = m_fold;
        m_fold   = nf;
        #1;
        qcode_in = tbl[m_prev];
    endtask

    // From IDLE: strobe in the first ACQUIRE cycle, confirm three cycles later.
    task automatic acquire_lock(input string tag);
        step();
        check({tag, " acq foldn"}, 32'(foldn), 32'd0);
        check({tag, " acq fold_first"}, 32'(fold_first), 32'd1);
        check({tag, " acq lock"}, 32'(lock), 32'd0);
        bx_strobe = 1'b1;
        step();
        bx_strobe = 1'b0;
        check({tag, " conf foldn"}, 32'(foldn), 32'd0);
        check({tag, " conf qvalid"}, 32'(qvalid), 32'd0);
        step();
        check({tag, " conf foldn1"}, 32'(foldn), 32'd1);
        step();
        check({tag, " conf foldn2"}, 32'(foldn), 32'd2);
        check({tag, " conf lock"}, 32'(lock), 32'd0);
        check({tag, " conf qvalid2"}, 32'(qvalid), 32'd0);
        bx_strobe = 1'b1;
        step();
        bx_strobe = 1'b0;
        check({tag, " lock rise"}, 32'(lock), 32'd1);
        check({tag, " lock foldn"}, 32'(foldn), 32'd0);
        check({tag, " lock qvalid"}, 32'(qvalid), 32'd0);
    endtask

    // One locked BX starting at foldn=0; verifies the result of the previous BX.
    task automatic run_bx(input string tag, input logic [17:0] e_out,
                          input logic [5:0] e_best, input logic [2:0] e_bf);
        step();
        check({tag, " qvalid"}, 32'(qvalid), 32'd1);
        check({tag, " qcode_out"}, 32'(qcode_out), 32'(e_out));
        check({tag, " qbest"}, 32'(qbest), 32'(e_best));
        check({tag, " qbest_fold"}, 32'(qbest_fold), 32'(e_bf));
        check({tag, " foldn1"}, 32'(foldn), 32'd1);
        step();
        check({tag, " qvalid off"}, 32'(qvalid), 32'd0);
        check({tag, " foldn2"}, 32'(foldn), 32'd2);
        bx_strobe = 1'b1;
        step();
        bx_strobe = 1'b0;
        check({tag, " qvalid off2"}, 32'(qvalid), 32'd0);
        check({tag, " foldn0"}, 32'(foldn), 32'd0);
        check({tag, " lock held"}, 32'(lock), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " foldn"}, 32'(foldn), 32'd0);
        check({tag, " fold_first"}, 32'(fold_first), 32'd0);
        check({tag, " qcode_out"}, 32'(qcode_out), 32'd0);
        check({tag, " qbest"}, 32'(qbest), 32'd0);
        check({tag, " qbest_fold"}, 32'(qbest_fold), 32'd0);
        check({tag, " qvalid"}, 32'(qvalid), 32'd0);
        check({tag, " lock"}, 32'(lock), 32'd0);
        check({tag, " sync_err"}, 32'(sync_err), 32'd0);
        check({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; bx_strobe = 1'b0; qcode_in = '0;
        m_fold = 3'd0; m_prev = 3'd0; m_active = 1'b0;
        tbl[0] = 6'h12; tbl[1] = 6'h3F; tbl[2] = 6'h3F;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Acquire and lock, then stream codes with ties and a later-fold maximum.
        acquire_lock("start");
        run_bx("bxA0", {6'h3F, 6'h3F, 6'h12}, 6'h3F, 3'd1);
        tbl[0] = 6'h3F; tbl[1] = 6'h00; tbl[2] = 6'h3F;
        run_bx("bxA1", {6'h3F, 6'h3F, 6'h12}, 6'h3F, 3'd1);
        tbl[0] = 6'h01; tbl[1] = 6'h02; tbl[2] = 6'h30;
        run_bx("bxB", {6'h3F, 6'h00, 6'h3F}, 6'h3F, 3'd0);
        run_bx("bxC", {6'h30, 6'h02, 6'h01}, 6'h30, 3'd2);

        // Strobe one cycle early while locked.
        step();
        bx_strobe = 1'b1;
        step();
        bx_strobe = 1'b0;
        check("early sync_err", 32'(sync_err), 32'd1);
        check("early err_cnt", 32'(err_cnt), 32'd1);
        check("early lock", 32'(lock), 32'd0);
        check("early foldn", 32'(foldn), 32'd0);
        check("early qvalid", 32'(qvalid), 32'd0);
        step();
        check("early sync_err off", 32'(sync_err), 32'd0);
        check("early foldn1", 32'(foldn), 32'd1);
        check("early qvalid1", 32'(qvalid), 32'd0);
        step();
        check("early foldn2", 32'(foldn), 32'd2);
        check("early qvalid2", 32'(qvalid), 32'd0);
        bx_strobe = 1'b1;
        step();
        bx_strobe = 1'b0;
        check("early relock", 32'(lock), 32'd1);
        check("early qvalid3", 32'(qvalid), 32'd0);
        check("early err_cnt held", 32'(err_cnt), 32'd1);
        run_bx("bxC2", {6'h30, 6'h02, 6'h01}, 6'h30, 3'd2);

        // Two dropped strobes.
        step(); step(); step();
        check("miss1 foldn", 32'(foldn), 32'd0);
        check("miss1 lock", 32'(lock), 32'd1);
        check("miss1 err_cnt", 32'(err_cnt), 32'd1);
        step();
        check("miss wrap1", 32'(foldn), 32'd1);
        step();
        check("miss wrap2", 32'(foldn), 32'd2);
        step();
        check("miss2 foldn", 32'(foldn), 32'd0);
        check("miss2 lock", 32'(lock), 32'd0);
        check("miss2 err_cnt", 32'(err_cnt), 32'd2);
        step();
        check("acq flywheel", 32'(foldn), 32'd1);
        step();
        step();
        check("acq flywheel wrap", 32'(foldn), 32'd0);

        // Held strobe: ACQUIRE->CONFIRM, then a misaligned strobe every cycle.
        bx_strobe = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("sat sync_err", 32'(sync_err), 32'd1);
        check("sat err_cnt", 32'(err_cnt), 32'd255);
        check("sat lock", 32'(lock), 32'd0);
        check("sat foldn", 32'(foldn), 32'd0);
        bx_strobe = 1'b0;

        // Relock, then reset asynchronously in the foldn=1 cycle.
        step(); step();
        bx_strobe = 1'b1;
        step();
        bx_strobe = 1'b0;
        check("relock lock", 32'(lock), 32'd1);
        check("sat err_cnt held", 32'(err_cnt), 32'd255);
        step();
        check("pre-reset foldn", 32'(foldn), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        rst_n    = 1'b1;
        m_fold   = 3'd0;
        m_active = 1'b0;
        acquire_lock("post-reset");
        run_bx("post-reset bx", {6'h30, 6'h02, 6'h01}, 6'h30, 3'd2);

        // Enable drop with a full BX pending: no qvalid, back to IDLE.
        en = 1'b0;
        step();
        check("en0 foldn", 32'(foldn), 32'd0);
        check("en0 lock", 32'(lock), 32'd0);
        check("en0 fold_first", 32'(fold_first), 32'd0);
        check("en0 qvalid", 32'(qvalid), 32'd0);
        step();
        check("en0 qvalid2", 32'(qvalid), 32'd0);
        en = 1'b1;
        acquire_lock("re-enable");
        run_bx("re-enable bx", {6'h30, 6'h02, 6'h01}, 6'h30, 3'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
